mem_arbiter: RTL and testbench

- Shares one single-port unified memory (req/ack handshake, variable latency) between the pipeline's instruction-fetch port and its MEM-stage data port.
- Serves data first, then instruction.
- Buffers each result and holds a global `stall` until every request presented in the current pipeline cycle has been served.
- Sits between the pipelined datapath's InstMemAddr/Inst and DataMemAddr/DataMemRead/DataMemWrite ports and the memory model.

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arbiter_if.sv | 31 +++
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and default widths for the unified-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int c_ADDR_W_DEF = 32;
    localparam int c_DATA_W_DEF = 32;
    localparam int c_CNT_W_DEF  = 32;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_DATA = 2'd1,
        ARB_INST = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mem_arbiter_if
// Description : Single-port memory bus (req/ack, variable latency).
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W_DEF,
    parameter int DATA_W = c_DATA_W_DEF
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one unified memory between fetch and data ports,
//               data first, stalling the pipeline until all requests are done.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W_DEF,
    parameter int DATA_W = c_DATA_W_DEF,
    parameter int CNT_W  = c_CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_data,
    output logic              if_ready,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              stall,
    mem_arbiter_if.master     mem,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam logic [1:0] c_ST_IDLE = ARB_IDLE;
    localparam logic [1:0] c_ST_DATA = ARB_DATA;
    localparam logic [1:0] c_ST_INST = ARB_INST;

    logic [1:0]        r_state;
    logic              r_inst_v;
    logic              r_data_v;
    logic [DATA_W-1:0] r_if_data;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [CNT_W-1:0]  r_stall_cycles;

    logic w_dm_any;
    logic w_dpend;
    logic w_ipend;
    logic w_stall;

    assign w_dm_any = dm_read | dm_write;
    assign w_dpend  = w_dm_any & ~r_data_v;
    assign w_ipend  = if_req & ~r_inst_v;
    assign w_stall  = w_dpend | w_ipend;

    assign stall         = w_stall;
    assign if_ready      = r_inst_v;
    assign dm_ready      = r_data_v;
    assign if_data       = r_if_data;
    assign dm_rdata      = r_dm_rdata;
    assign stall_cycles  = r_stall_cycles;
    assign mem.mem_req   = r_mem_req;
    assign mem.mem_we    = r_mem_we;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= c_ST_IDLE;
            r_inst_v       <= 1'b0;
            r_data_v       <= 1'b0;
            r_if_data      <= '0;
            r_dm_rdata     <= '0;
            r_mem_req      <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_stall_cycles <= '0;
        end else begin
            // Pipeline advances on this edge: results have been consumed.
            if (!w_stall) begin
                r_inst_v <= 1'b0;
                r_data_v <= 1'b0;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_dpend) begin
                        r_mem_addr  <= dm_addr;
                        r_mem_we    <= dm_write;
                        r_mem_wdata <= dm_wdata;
                        r_mem_req   <= 1'b1;
                        r_state     <= c_ST_DATA;
                    end else if (w_ipend) begin
                        r_mem_addr <= if_addr;
                        r_mem_we   <= 1'b0;
                        r_mem_req  <= 1'b1;
                        r_state    <= c_ST_INST;
                    end
                end
                c_ST_DATA: begin
                    if (mem.mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        // A withdrawn request still completes; its result is dropped.
                        if (w_dm_any) begin
                            r_data_v <= 1'b1;
                            if (!dm_write) begin
                                r_dm_rdata <= mem.mem_rdata;
                            end
                        end
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_INST: begin
                    if (mem.mem_ack) begin
                        r_mem_req <= 1'b0;
                        if (if_req) begin
                            r_inst_v  <= 1'b1;
                            r_if_data <= mem.mem_rdata;
                        end
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                    r_state   <= c_ST_IDLE;
                end
            endcase

            if (w_stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter with a latency-randomising
//               memory responder and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          lat;
    } txn_t;

    typedef struct {
        bit          iq;
        logic [31:0] ia;
        bit          rd;
        bit          wr;
        logic [31:0] da;
        logic [31:0] wd;
        int          lat;
        int          stall_len;
        bit          ifr;
        logic [31:0] ifd;
        bit          dmr;
        logic [31:0] dmd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        dm_read = 1'b0;
    logic        dm_write = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;

    logic [31:0] if_data, dm_rdata, stall_cycles;
    logic        if_ready, dm_ready, stall;
    logic [31:0] if_data4, dm_rdata4;
    logic        if_ready4, dm_ready4, stall4;
    logic [3:0]  stall_cycles4;

    logic        auto_ack = 1'b0;
    logic        man_ack = 1'b0;
    logic [31:0] rsp_rdata = '0;
    bit          auto_en = 1'b1;
    int          fixed_lat = 0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem_arr [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    txn_t        got_q [$];
    txn_t        exp_q [$];
    logic [31:0] exp_ifd = '0;
    logic [31:0] exp_dmd = '0;
    int          stall_total = 0;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus4 ();

    assign bus.mem_ack    = auto_ack | man_ack;
    assign bus.mem_rdata  = rsp_rdata;
    assign bus4.mem_ack   = bus.mem_ack;
    assign bus4.mem_rdata = bus.mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_ready(if_ready),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready), .stall(stall),
        .mem(bus), .stall_cycles(stall_cycles)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_data(if_data4), .if_ready(if_ready4),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata4), .dm_ready(dm_ready4), .stall(stall4),
        .mem(bus4), .stall_cycles(stall_cycles4)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h3C3C_0F0F;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_arr.exists(a) ? mem_arr[a] : dflt(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        mem_arr[a] = d;
        ref_mem[a] = d;
    endtask

    // Memory responder: fixed or random latency, records every completed access.
    initial begin : responder
        int          cnt;
        int          lat;
        logic [31:0] a0;
        logic [31:0] w0;
        logic        we0;
        txn_t        t;
        cnt = 0; lat = 1; a0 = '0; w0 = '0; we0 = 1'b0;
        forever begin
            @(negedge clk);
            auto_ack = 1'b0;
            if (rst || !bus.mem_req || !auto_en) begin
                cnt = 0;
            end else begin
                if (cnt == 0) begin
                    lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
                    a0  = bus.mem_addr;
                    we0 = bus.mem_we;
                    w0  = bus.mem_wdata;
                end else begin
                    chk("bus_hold_addr", bus.mem_addr, a0);
                    chk("bus_hold_we", 32'(bus.mem_we), 32'(we0));
                    if (we0) chk("bus_hold_wdata", bus.mem_wdata, w0);
                end
                cnt++;
                if (cnt == lat) begin
                    auto_ack = 1'b1;
                    if (we0) begin
                        mem_arr[a0] = w0;
                        rsp_rdata   = $urandom;
                    end else begin
                        rsp_rdata = mem_rd(a0);
                    end
                    t.addr = a0; t.we = we0; t.wdata = w0; t.lat = lat;
                    got_q.push_back(t);
                    cnt = 0;
                end
            end
        end
    end

    task automatic clear_inputs();
        if_req = 1'b0; if_addr = '0; dm_read = 1'b0; dm_write = 1'b0;
        dm_addr = '0; dm_wdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        exp_ifd = '0; exp_dmd = '0; stall_total = 0;
        got_q.delete();
    endtask

    // One pipeline cycle: present requests, wait out the stall, check results.
    task automatic run_op(input bit iq, input logic [31:0] ia, input bit rd, input bit wr,
                          input logic [31:0] da, input logic [31:0] wd,
                          output int n, output logic ifr, output logic [31:0] ifd,
                          output logic dmr, output logic [31:0] dmd);
        txn_t t;
        int   exp_len;
        int   sat;
        @(negedge clk);
        if_req = iq; if_addr = ia; dm_read = rd; dm_write = wr; dm_addr = da; dm_wdata = wd;
        exp_q.delete();
        if (rd || wr) begin
            t.addr = da; t.we = wr; t.wdata = wr ? wd : '0; t.lat = 0;
            exp_q.push_back(t);
            if (wr) ref_mem[da] = wd;
            else    exp_dmd = ref_rd(da);
        end
        if (iq) begin
            t.addr = ia; t.we = 1'b0; t.wdata = '0; t.lat = 0;
            exp_q.push_back(t);
            exp_ifd = ref_rd(ia);
        end
        #1;
        n = 0;
        while (stall && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (stall) chk("stall_timeout", 32'(stall), 32'd0);
        ifr = if_ready; ifd = if_data; dmr = dm_ready; dmd = dm_rdata;
        chk("if_ready", 32'(if_ready), 32'(iq));
        chk("if_data", if_data, exp_ifd);
        chk("dm_ready", 32'(dm_ready), 32'(rd | wr));
        chk("dm_rdata", dm_rdata, exp_dmd);
        chk("txn_count", 32'(got_q.size()), 32'(exp_q.size()));
        exp_len = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            chk("txn_addr", got_q[i].addr, exp_q[i].addr);
            chk("txn_we", 32'(got_q[i].we), 32'(exp_q[i].we));
            if (exp_q[i].we) chk("txn_wdata", got_q[i].wdata, exp_q[i].wdata);
            exp_len += got_q[i].lat + 1;
        end
        chk("stall_len", 32'(n), 32'(exp_len));
        stall_total += exp_len;
        sat = (stall_total > 15) ? 15 : stall_total;
        chk("stall_cycles", stall_cycles, 32'(stall_total));
        chk("stall_cycles_w4", 32'(stall_cycles4), 32'(sat));
        got_q.delete();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t        vt [7];
        int          n;
        logic        ifr, dmr;
        logic [31:0] ifd, dmd;
        int          k;
        bit          iq;
        int          op;

        vt[0] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,   32'h0,        3, 4, 1'b1, 32'h8C010004, 1'b0, 32'h0};
        vt[1] = '{1'b1, 32'h14, 1'b1, 1'b0, 32'h100, 32'h0,        2, 6, 1'b1, 32'h20420001, 1'b1, 32'hDEADBEEF};
        vt[2] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h200, 32'h12345678, 2, 3, 1'b0, 32'h20420001, 1'b1, 32'hDEADBEEF};
        vt[3] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h200, 32'h0,        1, 2, 1'b0, 32'h20420001, 1'b1, 32'h12345678};
        vt[4] = '{1'b1, 32'h204, 1'b1, 1'b1, 32'h204, 32'hCAFEF00D, 1, 4, 1'b1, 32'hCAFEF00D, 1'b1, 32'h12345678};
        vt[5] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        1, 0, 1'b0, 32'hCAFEF00D, 1'b0, 32'h12345678};
        vt[6] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,   32'h0,        4, 5, 1'b1, 32'h8C010004, 1'b0, 32'h12345678};

        preload(32'h10,  32'h8C010004);
        preload(32'h14,  32'h20420001);
        preload(32'h100, 32'hDEADBEEF);

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_if_ready", 32'(if_ready), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_stall_cycles", stall_cycles, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            fixed_lat = vt[i].lat;
            run_op(vt[i].iq, vt[i].ia, vt[i].rd, vt[i].wr, vt[i].da, vt[i].wd, n, ifr, ifd, dmr, dmd);
            chk($sformatf("vec%0d_stall_len", i), 32'(n), 32'(vt[i].stall_len));
            chk($sformatf("vec%0d_if_ready", i), 32'(ifr), 32'(vt[i].ifr));
            chk($sformatf("vec%0d_if_data", i), ifd, vt[i].ifd);
            chk($sformatf("vec%0d_dm_ready", i), 32'(dmr), 32'(vt[i].dmr));
            chk($sformatf("vec%0d_dm_rdata", i), dmd, vt[i].dmd);
        end

        // Reset while a data access is in flight
        auto_en = 1'b0;
        @(negedge clk);
        dm_read = 1'b1; dm_addr = 32'h300;
        @(negedge clk);
        #1;
        chk("midrst_req_before", 32'(bus.mem_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("midrst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("midrst_mem_addr", bus.mem_addr, 32'd0);
        chk("midrst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("midrst_if_data", if_data, 32'd0);
        chk("midrst_dm_rdata", dm_rdata, 32'd0);
        chk("midrst_dm_ready", 32'(dm_ready), 32'd0);
        chk("midrst_stall_cycles", stall_cycles, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        man_ack = 1'b1;
        rsp_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        man_ack = 1'b0;
        #1;
        chk("late_ack_mem_req", 32'(bus.mem_req), 32'd0);
        chk("late_ack_dm_ready", 32'(dm_ready), 32'd0);
        chk("late_ack_dm_rdata", dm_rdata, 32'd0);
        chk("late_ack_stall", 32'(stall), 32'd0);
        exp_ifd = '0; exp_dmd = '0; stall_total = 0;
        got_q.delete();
        auto_en = 1'b1;

        // Fetch withdrawn while in flight
        fixed_lat = 3;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h20;
        @(negedge clk);
        #1;
        chk("wd_mem_req", 32'(bus.mem_req), 32'd1);
        chk("wd_mem_addr", bus.mem_addr, 32'h20);
        if_req = 1'b0;
        #1;
        chk("wd_stall_dropped", 32'(stall), 32'd0);
        k = 0;
        while (got_q.size() == 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("wd_txn_seen", 32'(got_q.size()), 32'd1);
        @(negedge clk);
        #1;
        chk("wd_if_ready", 32'(if_ready), 32'd0);
        chk("wd_if_data", if_data, exp_ifd);
        chk("wd_mem_req_done", 32'(bus.mem_req), 32'd0);
        stall_total += 1;
        chk("wd_stall_cycles", stall_cycles, 32'(stall_total));
        got_q.delete();

        // Counter: 20 back-to-back fetches with 2-cycle ack
        do_reset();
        fixed_lat = 2;
        for (int i = 0; i < 20; i++) begin
            run_op(1'b1, 32'h40 + 32'(4 * i), 1'b0, 1'b0, 32'h0, 32'h0, n, ifr, ifd, dmr, dmd);
        end
        chk("cnt_total_60", stall_cycles, 32'd60);
        chk("cnt_w4_saturated", 32'(stall_cycles4), 32'd15);

        // Randomised traffic against the reference model
        fixed_lat = 0;
        for (int i = 0; i < 200; i++) begin
            iq = 1'($urandom_range(0, 1));
            op = int'($urandom_range(0, 3));
            run_op(iq, 32'h400 + {26'd0, 4'($urandom_range(0, 15)), 2'b00},
                   (op == 1) || (op == 3), (op == 2) || (op == 3),
                   32'h400 + {26'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom,
                   n, ifr, ifd, dmr, dmd);
        end

        clear_inputs();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
